fft_stream_host: RTL and testbench
==================================

// Module: fft_stream_host
// PURPOSE
//  Far-end partner of top_fft's stream ports. Holds a sample buffer loaded by the host, sources the
//  samples to top_fft over RDATA/RVALID/RREADY, then sinks the FFT results from WDATA/WVALID/WREADY
//  into a result buffer the host reads back. Sits between the host/test harness and top_fft.
// PARAMETERS
//  SAMP_WIDTH  16    width of one input sample (RDATA)
//  DATA_WIDTH  32    width of one result word (WDATA)
//  CNT_WIDTH   12    width of SAMP_NUMBER and buffer addresses; buffer depth = 2**CNT_WIDTH
// PORTS
//  clk          in   1           clock, all logic on rising edge
//  n_Reset      in   1           asynchronous active-low reset
//  start        in   1           1-cycle pulse, begins a run (IDLE only)
//  samp_number  in   CNT_WIDTH   samples per run, sampled on accepted start; driven to top_fft SAMP_NUMBER
//  mac_nradix   in   1           mode, sampled on accepted start
//  MAC_nRADIX   out  1           registered mode to top_fft
//  SAMP_NUMBER  out  CNT_WIDTH   registered sample count to top_fft
//  host_wr_en   in   1           sample buffer write strobe
//  host_wr_addr in   CNT_WIDTH   sample buffer write address
//  host_wr_data in   SAMP_WIDTH  sample buffer write data
//  host_rd_addr in   CNT_WIDTH   result buffer read address
//  host_rd_data out  DATA_WIDTH  result buffer read data, 1-cycle latency
//  RDATA        out  SAMP_WIDTH  sample to top_fft
//  RVALID       out  1           RDATA valid
//  RREADY       in   1           top_fft accepts sample
//  RBURST       in   2           burst type from top_fft, must be 2'b01 (INCR)
//  WDATA        in   DATA_WIDTH  result from top_fft
//  WVALID       in   1           WDATA valid
//  WREADY       out  1           block accepts result
//  WBURST       in   2           burst type from top_fft, must be 2'b01 (INCR)
//  busy         out  1           high in any state except IDLE
//  done         out  1           1-cycle pulse at end of run
//  err          out  1           sticky error, cleared by accepted start
// BEHAVIOUR
//  Reset: state IDLE; RVALID, WREADY, busy, done, err, MAC_nRADIX = 0; RDATA, SAMP_NUMBER, host_rd_data = 0;
//   indices = 0. Buffer contents are not cleared. Reset mid-run aborts immediately, no done pulse.
//  Transfer = VALID & READY at a rising edge. RDATA held stable while RVALID=1 and RREADY=0.
//  FSM: IDLE -start-> LOAD (1 cycle, prefetch sample[0]) -> SEND -> COLLECT -> DONE (1 cycle) -> IDLE.
//   IDLE: host writes applied; start with samp_number=0 -> DONE with err=1, no stream traffic.
//   SEND: RVALID=1, RDATA=sample[sidx]; on transfer sidx++; throughput 1 sample/cycle while RREADY=1;
//    RVALID rises the cycle after LOAD. Transfer with sidx=samp_number-1 -> COLLECT, RVALID=0 next cycle.
//   COLLECT: WREADY=1; on transfer result[widx]<=WDATA, widx++; transfer with widx=samp_number-1
//    -> DONE, WREADY=0 next cycle. WVALID outside COLLECT is ignored (WREADY=0).
//   DONE: done=1 for exactly one cycle, busy=0 the cycle after.
//  Errors (sticky err=1, run continues): RBURST!=2'b01 at an R transfer; WBURST!=2'b01 at a W transfer;
//   host_wr_en while busy (write dropped); start while busy (ignored).
//  Indices are CNT_WIDTH wide, count 0..samp_number-1, never wrap within a run.
//  host_rd_data = result[host_rd_addr] registered, readable in every state.
//  Simultaneous start and host_wr_en in IDLE: write applied, run starts; sample[0] sees the new write
//   only if its address differs from 0 (prefetch reads old value at same cycle).
// TESTING
//  Load 1,2,3 at addr 0..2, samp_number=3, RREADY=1 -> RVALID 3 consecutive cycles, RDATA 1,2,3, then 0.
//  Same run, RREADY toggles 1,0,1,0,1 -> RDATA holds during stalls, exactly 3 transfers, no duplicate.
//  COLLECT, WVALID=1 with WDATA 0xA,0xB,0xC -> host_rd_addr 0..2 reads 0xA,0xB,0xC; done one cycle.
//  start with samp_number=0 -> no RVALID/WREADY, done pulse 2 cycles later, err=1.
//  RBURST=2'b00 during SEND -> err=1, run completes, done pulses; next start clears err.
//  n_Reset low mid-SEND -> RVALID=0, busy=0 asynchronously, no done; fresh run afterwards passes.

Source files
------------

// File: rtl/fft_stream_host.sv
// Stream partner for top_fft: a host-loaded sample buffer is sourced over the R channel,
// then FFT results arriving on the W channel are captured into a host-readable result buffer.
module fft_stream_host #(
  parameter int unsigned SAMP_WIDTH = 16,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CNT_WIDTH  = 12
) (
  input  logic                  clk,
  input  logic                  n_Reset,
  input  logic                  start,
  input  logic [CNT_WIDTH-1:0]  samp_number,
  input  logic                  mac_nradix,
  output logic                  MAC_nRADIX,
  output logic [CNT_WIDTH-1:0]  SAMP_NUMBER,
  input  logic                  host_wr_en,
  input  logic [CNT_WIDTH-1:0]  host_wr_addr,
  input  logic [SAMP_WIDTH-1:0] host_wr_data,
  input  logic [CNT_WIDTH-1:0]  host_rd_addr,
  output logic [DATA_WIDTH-1:0] host_rd_data,
  output logic [SAMP_WIDTH-1:0] RDATA,
  output logic                  RVALID,
  input  logic                  RREADY,
  input  logic [1:0]            RBURST,
  input  logic [DATA_WIDTH-1:0] WDATA,
  input  logic                  WVALID,
  output logic                  WREADY,
  input  logic [1:0]            WBURST,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int unsigned DEPTH = 2 ** CNT_WIDTH;
  localparam logic [CNT_WIDTH-1:0] ONE = CNT_WIDTH'(1);
  localparam logic [1:0] BURST_INCR = 2'b01;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SEND,
    S_COLLECT,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [SAMP_WIDTH-1:0] samp_mem [DEPTH];
  logic [DATA_WIDTH-1:0] res_mem  [DEPTH];

  logic [CNT_WIDTH-1:0] sidx, widx, last_idx;
  logic start_ok, r_xfer, w_xfer, r_last, w_last, err_evt;

  assign last_idx = SAMP_NUMBER - ONE;
  assign start_ok = start && (state_q == S_IDLE);
  assign r_xfer   = (state_q == S_SEND) && RREADY;
  assign w_xfer   = (state_q == S_COLLECT) && WVALID;
  assign r_last   = r_xfer && (sidx == last_idx);
  assign w_last   = w_xfer && (widx == last_idx);
  assign err_evt  = (r_xfer && (RBURST != BURST_INCR)) ||
                    (w_xfer && (WBURST != BURST_INCR)) ||
                    (host_wr_en && busy) || (start && busy);

  // Every run passes through LOAD; an empty run takes LOAD -> DONE so it never touches the streams.
  always_comb begin
    state_d = state_q;
    busy    = (state_q != S_IDLE);
    RVALID  = (state_q == S_SEND);
    WREADY  = (state_q == S_COLLECT);
    done    = (state_q == S_DONE);
    unique case (state_q)
      S_IDLE:    if (start) state_d = S_LOAD;
      S_LOAD:    state_d = (SAMP_NUMBER == '0) ? S_DONE : S_SEND;
      S_SEND:    if (r_last) state_d = S_COLLECT;
      S_COLLECT: if (w_last) state_d = S_DONE;
      S_DONE:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_Reset) begin
    if (!n_Reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge n_Reset) begin
    if (!n_Reset) begin
      sidx         <= '0;
      widx         <= '0;
      SAMP_NUMBER  <= '0;
      MAC_nRADIX   <= 1'b0;
      RDATA        <= '0;
      err          <= 1'b0;
      host_rd_data <= '0;
    end else begin
      host_rd_data <= res_mem[host_rd_addr];
      if (start_ok) begin
        SAMP_NUMBER <= samp_number;
        MAC_nRADIX  <= mac_nradix;
        sidx        <= '0;
        widx        <= '0;
        // Prefetch reads the buffer before a same-edge host write lands
        RDATA       <= samp_mem[0];
        err         <= (samp_number == '0);
      end else begin
        if (err_evt) err <= 1'b1;
        if (r_xfer) begin
          sidx  <= sidx + ONE;
          RDATA <= r_last ? '0 : samp_mem[sidx + ONE];
        end
        if (w_xfer) widx <= widx + ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (host_wr_en && (state_q == S_IDLE)) samp_mem[host_wr_addr] <= host_wr_data;
    if (w_xfer) res_mem[widx] <= WDATA;
  end

endmodule

// File: tb/tb_fft_stream_host.sv
// Bench for fft_stream_host: directed stream sequences plus a table of randomized runs
// checked against a buffer-level model of the host/stream behaviour.
module tb_fft_stream_host;

  localparam int unsigned SW = 16;
  localparam int unsigned DW = 32;
  localparam int unsigned CW = 12;

  logic          clk = 1'b0;
  logic          n_Reset = 1'b0;
  logic          start = 1'b0;
  logic [CW-1:0] samp_number = '0;
  logic          mac_nradix = 1'b0;
  logic          MAC_nRADIX;
  logic [CW-1:0] SAMP_NUMBER;
  logic          host_wr_en = 1'b0;
  logic [CW-1:0] host_wr_addr = '0;
  logic [SW-1:0] host_wr_data = '0;
  logic [CW-1:0] host_rd_addr = '0;
  logic [DW-1:0] host_rd_data;
  logic [SW-1:0] RDATA;
  logic          RVALID;
  logic          RREADY = 1'b0;
  logic [1:0]    RBURST = 2'b01;
  logic [DW-1:0] WDATA = '0;
  logic          WVALID = 1'b0;
  logic          WREADY;
  logic [1:0]    WBURST = 2'b01;
  logic          busy, done, err;

  fft_stream_host #(.SAMP_WIDTH(SW), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .n_Reset(n_Reset), .start(start), .samp_number(samp_number),
    .mac_nradix(mac_nradix), .MAC_nRADIX(MAC_nRADIX), .SAMP_NUMBER(SAMP_NUMBER),
    .host_wr_en(host_wr_en), .host_wr_addr(host_wr_addr), .host_wr_data(host_wr_data),
    .host_rd_addr(host_rd_addr), .host_rd_data(host_rd_data),
    .RDATA(RDATA), .RVALID(RVALID), .RREADY(RREADY), .RBURST(RBURST),
    .WDATA(WDATA), .WVALID(WVALID), .WREADY(WREADY), .WBURST(WBURST),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic [SW-1:0] smodel [4096];
  logic [DW-1:0] rmodel [4096];

  typedef struct {
    int n; int rr_pct; int wv_pct;
    bit bad_r; bit bad_w; bit busy_wr; bit load;
    bit sw; int sw_addr; int sw_data;
    bit exp_err;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic host_write(input int addr, input int data);
    host_wr_en   = 1'b1;
    host_wr_addr = CW'(addr);
    host_wr_data = SW'(data);
    smodel[addr] = SW'(data);
    tick();
    host_wr_en = 1'b0;
  endtask

  task automatic read_back(input int n, input string name);
    for (int i = 0; i < n; i++) begin
      host_rd_addr = CW'(i);
      tick();
      chk(name, 64'(host_rd_data), 64'(rmodel[i]));
    end
  endtask

  task automatic do_start(input int n, input bit mode);
    start = 1'b1;
    samp_number = CW'(n);
    mac_nradix = mode;
    tick();
    start = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    int rgot, wgot, dones, cyc, done_cyc, rv_cyc;
    logic [SW-1:0] first;
    bit rinj, winj, rr, wv, mode;
    rgot = 0; wgot = 0; dones = 0; done_cyc = -1; rv_cyc = -1; rinj = 0; winj = 0;
    if (v.load) for (int i = 0; i < v.n; i++) host_write(i, int'($urandom_range(65535)));
    first = smodel[0];
    mode = 1'($urandom_range(1));
    if (v.sw) begin
      host_wr_en = 1'b1; host_wr_addr = CW'(v.sw_addr); host_wr_data = SW'(v.sw_data);
      smodel[v.sw_addr] = SW'(v.sw_data);
    end
    do_start(v.n, mode);
    host_wr_en = 1'b0;
    chk("start_busy", 64'(busy), 64'(1));
    chk("start_err", 64'(err), 64'(v.n == 0));
    chk("mode_reg", 64'(MAC_nRADIX), 64'(mode));
    chk("count_reg", 64'(SAMP_NUMBER), 64'(v.n));
    for (cyc = 0; cyc < 2000; cyc++) begin
      if (done) begin dones++; done_cyc = cyc; end
      if (RVALID && rv_cyc < 0) rv_cyc = cyc;
      if (!busy) break;
      rr = (int'($urandom_range(99)) < v.rr_pct);
      wv = (int'($urandom_range(99)) < v.wv_pct);
      RREADY = rr; WVALID = wv; WDATA = DW'($urandom);
      RBURST = 2'b01; WBURST = 2'b01; host_wr_en = 1'b0;
      if (RVALID && rr) begin
        chk("rdata", 64'(RDATA), 64'((rgot == 0) ? first : smodel[rgot]));
        if (v.bad_r && !rinj) begin RBURST = 2'b00; rinj = 1; end
        rgot++;
      end
      if (WREADY && wv) begin
        rmodel[wgot] = WDATA;
        if (v.bad_w && !winj) begin WBURST = 2'b11; winj = 1; end
        wgot++;
      end
      if (v.busy_wr && cyc == 3) begin
        host_wr_en = 1'b1; host_wr_addr = '0; host_wr_data = ~smodel[0];
      end
      tick();
    end
    RREADY = 1'b0; WVALID = 1'b0; host_wr_en = 1'b0; RBURST = 2'b01; WBURST = 2'b01;
    chk("run_timeout", 64'(cyc < 2000), 64'(1));
    chk("r_count", 64'(rgot), 64'(v.n));
    chk("w_count", 64'(wgot), 64'(v.n));
    chk("done_count", 64'(dones), 64'(1));
    chk("end_err", 64'(err), 64'(v.exp_err));
    if (v.n == 0) chk("empty_done_cyc", 64'(done_cyc), 64'(1));
    else chk("rvalid_latency", 64'(rv_cyc), 64'(1));
    read_back(v.n, "readback");
  endtask

  int rv_exp [9] = '{0, 1, 1, 1, 0, 0, 0, 0, 0};
  int rd_exp [9] = '{0, 1, 2, 3, 0, 0, 0, 0, 0};
  int wr_exp [9] = '{0, 0, 0, 0, 1, 1, 1, 0, 0};
  int dn_exp [9] = '{0, 0, 0, 0, 0, 0, 0, 1, 0};
  int rr_pat [7] = '{0, 1, 0, 1, 0, 1, 0};
  int rd_pat [7] = '{0, 1, 2, 2, 3, 3, 0};

  initial begin
    int xfers, c;
    vecs[0] = '{3, 100, 100, 0, 0, 0, 1, 0, 0, 0, 0};
    vecs[1] = '{3, 50, 100, 0, 0, 0, 1, 0, 0, 0, 0};
    vecs[2] = '{8, 70, 60, 1, 0, 0, 1, 0, 0, 0, 1};
    vecs[3] = '{5, 100, 40, 0, 1, 0, 1, 0, 0, 0, 1};
    vecs[4] = '{6, 60, 60, 0, 0, 1, 1, 0, 0, 0, 1};
    vecs[5] = '{6, 80, 80, 0, 0, 0, 0, 0, 0, 0, 0};
    vecs[6] = '{0, 100, 100, 0, 0, 0, 0, 0, 0, 0, 1};
    vecs[7] = '{17, 50, 50, 0, 0, 0, 1, 0, 0, 0, 0};
    vecs[8] = '{4, 90, 90, 0, 0, 0, 1, 1, 0, 16'h5A5A, 0};
    vecs[9] = '{4, 90, 90, 0, 0, 0, 0, 1, 1, 16'h1234, 0};

    #12;
    chk("rst_rvalid", 64'(RVALID), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_err", 64'(err), 64'(0));
    chk("rst_rdata", 64'(RDATA), 64'(0));
    chk("rst_count", 64'(SAMP_NUMBER), 64'(0));
    n_Reset = 1'b1;
    tick();

    // Three samples at full throughput, then three results
    host_write(0, 1); host_write(1, 2); host_write(2, 3);
    RREADY = 1'b1;
    do_start(3, 1'b0);
    for (int i = 0; i < 9; i++) begin
      chk("seq_rvalid", 64'(RVALID), 64'(rv_exp[i]));
      if (i >= 1 && i <= 4) chk("seq_rdata", 64'(RDATA), 64'(rd_exp[i]));
      chk("seq_wready", 64'(WREADY), 64'(wr_exp[i]));
      chk("seq_done", 64'(done), 64'(dn_exp[i]));
      WVALID = (wr_exp[i] == 1);
      WDATA = DW'(32'hA + i - 4);
      if (WVALID) rmodel[i - 4] = WDATA;
      tick();
    end
    chk("seq_idle", 64'(busy), 64'(0));
    WVALID = 1'b0; RREADY = 1'b0;
    read_back(3, "seq_readback");

    // RREADY stalls: RDATA must hold and no sample repeats
    xfers = 0;
    do_start(3, 1'b0);
    for (int i = 0; i < 7; i++) begin
      RREADY = rr_pat[i][0];
      if (i >= 1 && i <= 5) chk("stall_rdata", 64'(RDATA), 64'(rd_pat[i]));
      if (RVALID && RREADY) xfers++;
      tick();
    end
    chk("stall_xfers", 64'(xfers), 64'(3));
    chk("stall_rvalid_off", 64'(RVALID), 64'(0));
    RREADY = 1'b0; WVALID = 1'b1;
    for (c = 0; c < 50 && busy; c++) tick();
    chk("stall_finish", 64'(c < 50), 64'(1));
    WVALID = 1'b0;

    // Asynchronous reset while stalled in SEND
    do_start(5, 1'b1);
    tick();
    chk("abort_in_send", 64'(RVALID), 64'(1));
    #3 n_Reset = 1'b0;
    #1;
    chk("abort_rvalid", 64'(RVALID), 64'(0));
    chk("abort_busy", 64'(busy), 64'(0));
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("abort_no_done", 64'(done), 64'(0));
    end
    n_Reset = 1'b1;
    tick();

    foreach (vecs[i]) run_vec(vecs[i]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
